// File: rtl/order_content_ctrl.sv
// order_content RAM front-end: zero sweep after reset, then
// WRITE/READ/CLEAR serialised onto port A with a 2-deep read buffer.
module order_content_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 200
) (
  input  logic                  axis_aclk,
  input  logic                  axis_resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic                  ram_we_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_a
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] sweep;

  logic                  rd_inflight;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [ADDR_WIDTH-1:0] buf_addr [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            buf_count;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [2:0]            occ;

  assign rsp_valid = (buf_count != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = rd_inflight;

  // a pop this cycle frees a slot in time for a read issued now
  assign occ = {1'b0, buf_count}
             + {2'b00, rd_inflight}
             - {2'b00, pop};

  assign cmd_ready = (state == S_RUN) && (occ < 3'd2);
  assign accept    = cmd_valid && cmd_ready;

  assign rsp_data = buf_data[rd_ptr];
  assign rsp_addr = buf_addr[rd_ptr];

  always_comb begin
    ram_we_a   = 1'b0;
    ram_addr_a = cmd_addr;
    ram_din_a  = '0;
    unique case (1'b1)
      (state == S_INIT): begin
        ram_we_a   = 1'b1;
        ram_addr_a = sweep;
      end
      (accept && cmd_op == OP_WR): begin
        ram_we_a  = 1'b1;
        ram_din_a = cmd_data;
      end
      (accept && cmd_op == OP_CLR): begin
        ram_we_a = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state     <= S_INIT;
      sweep     <= '0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        S_INIT: begin
          sweep <= sweep + A_ONE;
          if (sweep == '1) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN: begin
        end
        default: state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      rd_inflight <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      rd_inflight <= accept && (cmd_op == OP_RD);
      if (accept && cmd_op == OP_RD) begin
        rd_addr_q <= cmd_addr;
      end
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_addr[0] <= '0;
      buf_addr[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      buf_count   <= 2'd0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= ram_dout_a;
        buf_addr[wr_ptr] <= rd_addr_q;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   buf_count <= buf_count + 2'd1;
        2'b01:   buf_count <= buf_count - 2'd1;
        default: buf_count <= buf_count;
      endcase
    end
  end

endmodule

// File: tb/tb_order_content_ctrl.sv
// Directed bench for order_content_ctrl with a behavioural
// 4096x200 RAM model on port A.
module tb_order_content_ctrl;

  localparam int AW = 12;
  localparam int DW = 200;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] RD  = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  localparam logic [DW-1:0] DA5 = {25{8'hA5}};
  localparam logic [DW-1:0] D1  = {25{8'h11}};
  localparam logic [DW-1:0] D2  = {25{8'h22}};
  localparam logic [DW-1:0] D3  = {25{8'h33}};
  localparam logic [DW-1:0] DX  = {25{8'h5C}};

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic          init_done;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_din_a;
  logic          ram_we_a;
  logic [DW-1:0] ram_dout_a;

  logic [DW-1:0] ram [4096];

  int n_cmp = 0;
  int n_err = 0;
  int outst = 0;
  int ovf_bad = 0;

  logic          last_we;
  logic [DW-1:0] last_din;
  int            last_wait;

  logic [AW-1:0] q_addr [4];
  logic [DW-1:0] q_data [4];
  logic [AW-1:0] got_a  [4];
  logic [DW-1:0] got_d  [4];
  int            n_got;

  order_content_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .axis_aclk  (clk),
    .axis_resetn(rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_addr   (rsp_addr),
    .rsp_data   (rsp_data),
    .init_done  (init_done),
    .ram_addr_a (ram_addr_a),
    .ram_din_a  (ram_din_a),
    .ram_we_a   (ram_we_a),
    .ram_dout_a (ram_dout_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_a) ram[ram_addr_a] <= ram_din_a;
    ram_dout_a <= ram[ram_addr_a];
  end

  // outstanding reads (in flight + buffered) must never exceed 2
  always @(negedge clk) begin
    if (!rst_n) begin
      outst = 0;
    end else begin
      if (cmd_valid && cmd_ready && cmd_op == RD) outst = outst + 1;
      if (rsp_valid && rsp_ready) outst = outst - 1;
      if (outst > 2) ovf_bad = ovf_bad + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called just after a posedge; returns just after the accepting edge
  task automatic send(input logic [1:0] op,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", cmd_ready, 1);
    last_wait = n;
    last_we   = ram_we_a;
    last_din  = ram_din_a;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({tag, "_timeout"}, rsp_valid, 1);
    chk({tag, "_addr"}, rsp_addr, a);
    chk({tag, "_data"}, rsp_data, d);
    @(posedge clk);
    #1;
  endtask

  // issue n READs from q_addr every cycle, collect responses
  task automatic run_burst(input int n, output int stalls);
    int idx;
    logic acc;
    idx    = 0;
    n_got  = 0;
    stalls = 0;
    for (int c = 0; c < 20; c++) begin
      cmd_valid = (idx < n);
      cmd_op    = RD;
      cmd_addr  = q_addr[idx < n ? idx : 0];
      @(negedge clk);
      if (rsp_valid && rsp_ready && n_got < 4) begin
        got_a[n_got] = rsp_addr;
        got_d[n_got] = rsp_data;
        n_got++;
      end
      acc = cmd_valid && cmd_ready;
      if (cmd_valid && !cmd_ready) stalls++;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    int bad_sweep;
    int bad_rdy;
    int bad_nop;
    int stalls;
    int n;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    cmd_addr  = '0;
    cmd_data  = '0;
    rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_rsp_data", rsp_data, 0);

    // 1: init sweep
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad_sweep = 0;
    bad_rdy   = 0;
    for (int i = 0; i < 4096; i++) begin
      logic [AW-1:0] ia;
      ia = i[AW-1:0];
      @(negedge clk);
      if (!(ram_we_a === 1'b1 && ram_addr_a === ia
            && ram_din_a === '0)) bad_sweep++;
      if (cmd_ready !== 1'b0 || init_done !== 1'b0) bad_rdy++;
    end
    chk("sweep_writes", bad_sweep, 0);
    chk("sweep_no_ready", bad_rdy, 0);
    @(negedge clk);
    chk("init_done", init_done, 1);
    chk("post_init_we", ram_we_a, 0);
    chk("post_init_ready", cmd_ready, 1);
    @(posedge clk);
    #1;

    // 2: write then read same slot next cycle
    send(WR, 12'h005, DA5);
    chk("t2_wr_we", last_we, 1);
    chk("t2_wr_din", last_din, DA5);
    send(RD, 12'h005, '0);
    chk("t2_rd_no_wait", last_wait, 0);
    @(negedge clk);
    chk("t2_not_early", rsp_valid, 0);
    @(negedge clk);
    chk("t2_valid", rsp_valid, 1);
    chk("t2_addr", rsp_addr, 12'h005);
    chk("t2_data", rsp_data, DA5);
    @(posedge clk);
    #1;

    // 3: untouched slot reads zero
    send(RD, 12'hFFF, '0);
    get_rsp("t3", 12'hFFF, '0);

    // 4: backpressure with three reads
    send(WR, 12'h001, D1);
    send(WR, 12'h002, D2);
    send(WR, 12'h003, D3);
    rsp_ready = 1'b0;
    send(RD, 12'h001, '0);
    send(RD, 12'h002, '0);
    cmd_valid = 1'b1;
    cmd_op    = RD;
    cmd_addr  = 12'h003;
    @(negedge clk);
    chk("t4_stall", cmd_ready, 0);
    repeat (3) @(negedge clk);
    chk("t4_stall_hold", cmd_ready, 0);
    chk("t4_hold_valid", rsp_valid, 1);
    chk("t4_hold_addr", rsp_addr, 12'h001);
    chk("t4_hold_data", rsp_data, D1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    q_addr[0] = 12'h003;
    n_got = 0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      logic acc;
      @(negedge clk);
      if (rsp_valid && n_got < 4) begin
        got_a[n_got] = rsp_addr;
        got_d[n_got] = rsp_data;
        n_got++;
      end
      acc = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        cmd_valid = 1'b0;
        n++;
      end
    end
    chk("t4_third_accepted", n, 1);
    chk("t4_count", n_got, 3);
    chk("t4_a0", got_a[0], 12'h001);
    chk("t4_d0", got_d[0], D1);
    chk("t4_a1", got_a[1], 12'h002);
    chk("t4_d1", got_d[1], D2);
    chk("t4_a2", got_a[2], 12'h003);
    chk("t4_d2", got_d[2], D3);

    // back-to-back reads with rsp_ready held high
    q_addr[0] = 12'h003;
    q_addr[1] = 12'h005;
    q_addr[2] = 12'h001;
    q_addr[3] = 12'h002;
    q_data[0] = D3;
    q_data[1] = DA5;
    q_data[2] = D1;
    q_data[3] = D2;
    run_burst(4, stalls);
    chk("burst_stalls", stalls, 0);
    chk("burst_count", n_got, 4);
    for (int k = 0; k < 4; k++) begin
      chk("burst_addr", got_a[k], q_addr[k]);
      chk("burst_data", got_d[k], q_data[k]);
    end

    // 5: write, clear, read; NOP
    send(WR, 12'h010, DX);
    send(CLR, 12'h010, DX);
    chk("t5_clr_we", last_we, 1);
    chk("t5_clr_din", last_din, '0);
    send(RD, 12'h010, '0);
    get_rsp("t5", 12'h010, '0);
    send(NOP, 12'h020, DX);
    chk("t5_nop_we", last_we, 0);
    bad_nop = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || ram_we_a !== 1'b0) bad_nop++;
    end
    chk("t5_nop_quiet", bad_nop, 0);
    @(posedge clk);
    #1;

    // 6: reset with two buffered responses
    rsp_ready = 1'b0;
    send(RD, 12'h005, '0);
    send(RD, 12'h001, '0);
    repeat (2) @(negedge clk);
    chk("t6_buffered", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", rsp_valid, 0);
    chk("t6_rst_ready", cmd_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t6_sweep0_we", ram_we_a, 1);
    chk("t6_sweep0_addr", ram_addr_a, 12'h000);
    @(negedge clk);
    chk("t6_sweep1_addr", ram_addr_a, 12'h001);
    chk("t6_no_rsp", rsp_valid, 0);
    n = 0;
    while (!init_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reinit", init_done, 1);
    @(posedge clk);
    #1;
    send(RD, 12'h005, '0);
    get_rsp("t6_cleared", 12'h005, '0);

    chk("no_overflow", ovf_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
